dcache_wt: RTL and testbench
============================

# dcache_wt

Direct-mapped, write-through, no-write-allocate data cache between the pipeline's MEM stage and the data memory port. Line = 4 × 16-bit words, matching the memory's 64-bit line read bus. Single-cycle hits. On a miss it stalls the pipeline, fills the line from memory, then completes the access. It also exports the dcache access and miss counters used by the bench summary.

## Interface
Parameters:
- WORD_SIZE, 16, data and address width
- NUM_LINES, 4, number of cache lines; power of two, ≥2
- IDX_BITS, log2(NUM_LINES), index width (derived)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- cpu_read  in  1  load request
- cpu_write  in  1  store request; takes priority if asserted together with cpu_read
- cpu_address  in  WORD_SIZE  word address; held stable while cpu_ready=0
- cpu_wdata  in  WORD_SIZE  store data
- cpu_rdata  out  WORD_SIZE  load data; valid when cpu_ready=1 and cpu_read=1
- cpu_ready  out  1  access completes this cycle; when low the pipeline stalls
- mem_readM  out  1  line fill request
- mem_writeM  out  1  word write request
- mem_address  out  WORD_SIZE  line-aligned address for fills ([1:0]=0); word address for writes
- mem_wdata  out  WORD_SIZE  write word
- mem_line  in  4*WORD_SIZE  fill data; word k is at bits [16k+15:16k]
- mem_readyM  in  1  one-cycle pulse: mem_line is valid
- mem_doneM  in  1  one-cycle pulse: write has been committed
- num_dcache_access  out  16  completed accesses
- num_dcache_miss  out  16  misses

## Operation
- Address split: offset = addr[1:0]; index = addr[2+IDX_BITS-1:2]; tag = remaining upper bits.
- Per line: valid bit, tag, 4 data words.
- hit = valid[index] && tag match.
- FSM states: IDLE, FILL, WRITE.
- IDLE, no request: cpu_ready=1; mem_readM=0; mem_writeM=0.
- IDLE, read hit: cpu_ready=1 combinationally; cpu_rdata = line word[offset].
- IDLE, read miss: cpu_ready=0; next state FILL; num_dcache_miss+1.
- IDLE, any write: cpu_ready=0; next state WRITE.
  - On a write hit, the cached word is updated at the edge that leaves WRITE, not before.
  - On a write miss, num_dcache_miss+1 on the IDLE→WRITE edge, and the line is left untouched (no allocate).
- FILL:
  - mem_readM=1 and mem_address = {addr[15:2],2'b00} are held until mem_readyM.
  - On mem_readyM: install line, set valid and tag, return to IDLE. The re-evaluated access then hits.
- WRITE:
  - mem_writeM=1, mem_address=cpu_address and mem_wdata=cpu_wdata are held until mem_doneM.
  - On mem_doneM: update the cached word if the address hits; cpu_ready=1 in that same cycle; return to IDLE.
- num_dcache_access increments by 1 on every cycle where cpu_ready=1 and (cpu_read|cpu_write). Each access is therefore counted exactly once.
- Both counters wrap at 16'hFFFF→0.
- mem_readM and mem_writeM are never asserted together.

## Timing
- Reset values:
  - All valid bits = 0; state = IDLE; both counters = 0.
  - mem_readM = 0, mem_writeM = 0; cpu_ready = 1; cpu_rdata = 0.
- Read hit: 0 extra cycles; the data is combinational in the request cycle.
- Read miss with memory latency L (cycles from mem_readM assertion to the mem_readyM pulse): the access completes L+1 cycles after the request cycle.
- Write with memory latency L: cpu_ready rises in the mem_doneM cycle.
- If cpu_read and cpu_write both drop while in FILL, the fill still completes and the line is installed; no access is counted.
- A mem_readyM or mem_doneM arriving in IDLE is ignored.
- Reset asserted mid-FILL or mid-WRITE: the operation is aborted, state returns to IDLE, and valid bits are cleared. No partial line is ever installed.
- Two addresses with the same index and different tags evict each other. The old line is simply overwritten; there is no writeback, since memory is always current.

## Test plan
- After reset, read 0x0010 with memory holding 0x1234 there: cpu_ready low, mem_readM with mem_address 0x0010, fill after 3 cycles. cpu_rdata = 0x1234 on cycle 4. Counters access = 1, miss = 1.
- Read 0x0011, 0x0012 and 0x0013 back-to-back after that fill: each completes in 1 cycle. access = 4, miss = 1, no memory traffic.
- Write 0xBEEF to 0x0012 (hit): mem_writeM with address 0x0012 and data 0xBEEF until mem_doneM. A following read of 0x0012 returns 0xBEEF in 1 cycle.
- Write 0x00AA to 0x0040 (miss, not resident): exactly one memory write, miss = +1. A following read of 0x0040 misses and fills.
- Conflict at NUM_LINES=4: read 0x0000, then 0x0010, then 0x0000. All three miss (miss = 3) and the final data is correct.
- Assert reset during FILL of 0x0020: after release, cpu_ready = 1 and counters = 0. A read of 0x0020 misses again; a stray mem_readyM pulse arriving in IDLE changes nothing.

Source files
------------

// File: rtl/dcache_wt.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wt
// Brief    : Direct-mapped, write-through, no-write-allocate data cache that
//            sits between the pipeline MEM stage and the data memory port.
//            Each line holds 4 words, the width of the memory's line read bus.
//            Read hits complete in the request cycle; misses stall the
//            pipeline while the line is filled from memory.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            cpu_read / cpu_write  - load / store request (store wins)
//            cpu_address, cpu_wdata, cpu_rdata, cpu_ready - pipeline side
//            mem_readM, mem_writeM, mem_address, mem_wdata - memory requests
//            mem_line, mem_readyM, mem_doneM               - memory responses
//            num_dcache_access, num_dcache_miss            - event counters
// Revision : 1.0 - initial release
// ============================================================================
module dcache_wt #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_LINES = 4,
    parameter int IDX_BITS  = $clog2(NUM_LINES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_read,
    input  logic                   cpu_write,
    input  logic [WORD_SIZE-1:0]   cpu_address,
    input  logic [WORD_SIZE-1:0]   cpu_wdata,
    output logic [WORD_SIZE-1:0]   cpu_rdata,
    output logic                   cpu_ready,
    output logic                   mem_readM,
    output logic                   mem_writeM,
    output logic [WORD_SIZE-1:0]   mem_address,
    output logic [WORD_SIZE-1:0]   mem_wdata,
    input  logic [4*WORD_SIZE-1:0] mem_line,
    input  logic                   mem_readyM,
    input  logic                   mem_doneM,
    output logic [15:0]            num_dcache_access,
    output logic [15:0]            num_dcache_miss
);

    localparam int c_TAG_BITS  = WORD_SIZE - 2 - IDX_BITS;
    localparam int c_LINE_BITS = WORD_SIZE - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [NUM_LINES-1:0]   r_valid;
    logic [c_TAG_BITS-1:0]  r_tag  [NUM_LINES];
    logic [WORD_SIZE-1:0]   r_data [NUM_LINES][4];
    // Line address of the outstanding fill, captured when the miss is taken
    // so the install lands in the right line even if the pipeline drops the
    // request while the fill is in flight.
    logic [c_LINE_BITS-1:0] r_fill_line;
    logic [15:0]            r_num_access;
    logic [15:0]            r_num_miss;

    logic [1:0]             w_offset;
    logic [IDX_BITS-1:0]    w_index;
    logic [c_TAG_BITS-1:0]  w_tag;
    logic                   w_hit;
    logic                   w_req;
    logic [IDX_BITS-1:0]    w_fill_index;
    logic [c_TAG_BITS-1:0]  w_fill_tag;

    assign w_offset     = cpu_address[1:0];
    assign w_index      = cpu_address[2 +: IDX_BITS];
    assign w_tag        = cpu_address[WORD_SIZE-1 -: c_TAG_BITS];
    assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_req        = cpu_read | cpu_write;
    assign w_fill_index = r_fill_line[IDX_BITS-1:0];
    assign w_fill_tag   = r_fill_line[c_LINE_BITS-1 -: c_TAG_BITS];

    assign num_dcache_access = r_num_access;
    assign num_dcache_miss   = r_num_miss;

    // Output decode; memory-side strobes depend only on the state register,
    // so read and write requests are mutually exclusive by construction.
    always_comb begin
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        mem_readM   = 1'b0;
        mem_writeM  = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        case (r_state)
            S_IDLE: begin
                // Any store leaves IDLE first; only a read hit completes here.
                cpu_ready = !w_req || (!cpu_write && w_hit);
                if (cpu_read && !cpu_write && w_hit) begin
                    cpu_rdata = r_data[w_index][w_offset];
                end
            end
            S_FILL: begin
                mem_readM   = 1'b1;
                mem_address = {r_fill_line, 2'b00};
            end
            S_WRITE: begin
                mem_writeM  = 1'b1;
                mem_address = cpu_address;
                mem_wdata   = cpu_wdata;
                cpu_ready   = mem_doneM;
            end
            default: begin
                cpu_ready = 1'b0;
            end
        endcase
    end

    // Control state, valid bits and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_fill_line  <= '0;
            r_num_access <= 16'd0;
            r_num_miss   <= 16'd0;
        end else begin
            if (cpu_ready && w_req) begin
                r_num_access <= r_num_access + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (cpu_write) begin
                        r_state <= S_WRITE;
                        if (!w_hit) begin
                            r_num_miss <= r_num_miss + 16'd1;
                        end
                    end else if (cpu_read && !w_hit) begin
                        r_state     <= S_FILL;
                        r_fill_line <= cpu_address[WORD_SIZE-1:2];
                        r_num_miss  <= r_num_miss + 16'd1;
                    end
                end
                S_FILL: begin
                    if (mem_readyM) begin
                        r_valid[w_fill_index] <= 1'b1;
                        r_state               <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (mem_doneM) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data storage need no reset: they are only observed through a
    // set valid bit. Updates are suppressed under reset so an aborted fill
    // or write never leaves a partial line behind.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_FILL && mem_readyM) begin
                r_tag[w_fill_index]        <= w_fill_tag;
                r_data[w_fill_index][2'd0] <= mem_line[0*WORD_SIZE +: WORD_SIZE];
                r_data[w_fill_index][2'd1] <= mem_line[1*WORD_SIZE +: WORD_SIZE];
                r_data[w_fill_index][2'd2] <= mem_line[2*WORD_SIZE +: WORD_SIZE];
                r_data[w_fill_index][2'd3] <= mem_line[3*WORD_SIZE +: WORD_SIZE];
            end
            // Write-through: the cached copy changes only as the memory write
            // commits, and only when the line is resident (no allocate).
            if (r_state == S_WRITE && mem_doneM && w_hit) begin
                r_data[w_index][w_offset] <= cpu_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_wt.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_wt
// Brief    : Directed self-checking bench for dcache_wt with a small
//            fixed-latency memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_wt;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [15:0] cpu_address = 16'h0;
    logic [15:0] cpu_wdata = 16'h0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_readM;
    logic        mem_writeM;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [63:0] mem_line = 64'h0;
    logic        mem_readyM = 1'b0;
    logic        mem_doneM = 1'b0;
    logic [15:0] num_dcache_access;
    logic [15:0] num_dcache_miss;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model state
    logic [15:0] model [0:255];
    logic        resp_en = 1'b1;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          fill_cnt = 0;
    int          write_cnt = 0;
    logic [15:0] last_fill_addr = 16'h0;
    logic [15:0] last_wr_addr = 16'h0;
    logic [15:0] last_wr_data = 16'h0;
    logic        both_seen = 1'b0;

    dcache_wt #(.WORD_SIZE(16), .NUM_LINES(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_read          (cpu_read),
        .cpu_write         (cpu_write),
        .cpu_address       (cpu_address),
        .cpu_wdata         (cpu_wdata),
        .cpu_rdata         (cpu_rdata),
        .cpu_ready         (cpu_ready),
        .mem_readM         (mem_readM),
        .mem_writeM        (mem_writeM),
        .mem_address       (mem_address),
        .mem_wdata         (mem_wdata),
        .mem_line          (mem_line),
        .mem_readyM        (mem_readyM),
        .mem_doneM         (mem_doneM),
        .num_dcache_access (num_dcache_access),
        .num_dcache_miss   (num_dcache_miss)
    );

    always #5 clk = ~clk;

    // Responder: a request held for LAT negedges gets a one-cycle response.
    always @(negedge clk) begin
        logic [7:0] a;
        if (mem_readM && mem_writeM) both_seen = 1'b1;
        if (resp_en) begin
            mem_readyM = 1'b0;
            mem_doneM  = 1'b0;
            if (mem_readM) begin
                rd_cnt++;
                if (rd_cnt == LAT) begin
                    a = mem_address[7:0];
                    mem_line = {model[a+8'd3], model[a+8'd2], model[a+8'd1], model[a]};
                    mem_readyM = 1'b1;
                    last_fill_addr = mem_address;
                    fill_cnt++;
                    rd_cnt = 0;
                end
            end else begin
                rd_cnt = 0;
            end
            if (mem_writeM) begin
                wr_cnt++;
                if (wr_cnt == LAT) begin
                    model[mem_address[7:0]] = mem_wdata;
                    mem_doneM = 1'b1;
                    last_wr_addr = mem_address;
                    last_wr_data = mem_wdata;
                    write_cnt++;
                    wr_cnt = 0;
                end
            end else begin
                wr_cnt = 0;
            end
        end else begin
            rd_cnt = 0;
            wr_cnt = 0;
        end
    end

    // Issue one access and wait (bounded) for cpu_ready. cyc is the number of
    // stall cycles before completion; 50 means it never completed.
    task automatic do_access(input logic wr, input logic [15:0] addr,
                             input logic [15:0] wd, output int cyc,
                             output logic [15:0] rd);
        @(negedge clk);
        cpu_write   = wr;
        cpu_read    = !wr;
        cpu_address = addr;
        cpu_wdata   = wd;
        #1;
        cyc = 0;
        while (!cpu_ready && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        rd = cpu_rdata;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (cpu_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b exp 1", cpu_ready); end
        n_checks++; if (mem_readM !== 1'b0) begin n_errors++; $display("FAIL reset_readM got %b exp 0", mem_readM); end
        n_checks++; if (mem_writeM !== 1'b0) begin n_errors++; $display("FAIL reset_writeM got %b exp 0", mem_writeM); end
        n_checks++; if (cpu_rdata !== 16'h0) begin n_errors++; $display("FAIL reset_rdata got %h exp 0000", cpu_rdata); end
        n_checks++; if (num_dcache_access !== 16'd0) begin n_errors++; $display("FAIL reset_access got %0d exp 0", num_dcache_access); end
        n_checks++; if (num_dcache_miss !== 16'd0) begin n_errors++; $display("FAIL reset_miss got %0d exp 0", num_dcache_miss); end
    endtask

    task automatic test_read_miss();
        int cyc;
        logic [15:0] rd;
        do_access(1'b0, 16'h0010, 16'h0, cyc, rd);
        idle_cycle();
        n_checks++; if (cyc !== 4) begin n_errors++; $display("FAIL miss_cycles got %0d exp 4", cyc); end
        n_checks++; if (rd !== 16'h1234) begin n_errors++; $display("FAIL miss_rdata got %h exp 1234", rd); end
        n_checks++; if (fill_cnt !== 1) begin n_errors++; $display("FAIL miss_fills got %0d exp 1", fill_cnt); end
        n_checks++; if (last_fill_addr !== 16'h0010) begin n_errors++; $display("FAIL miss_fill_addr got %h exp 0010", last_fill_addr); end
        n_checks++; if (num_dcache_access !== 16'd1) begin n_errors++; $display("FAIL miss_access got %0d exp 1", num_dcache_access); end
        n_checks++; if (num_dcache_miss !== 16'd1) begin n_errors++; $display("FAIL miss_miss got %0d exp 1", num_dcache_miss); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [15:0] rd;
        logic [15:0] exp_data [3];
        exp_data[0] = 16'hA511;
        exp_data[1] = 16'hA512;
        exp_data[2] = 16'hA513;
        for (int i = 0; i < 3; i++) begin
            do_access(1'b0, 16'h0011 + 16'(i), 16'h0, cyc, rd);
            n_checks++; if (cyc !== 0) begin n_errors++; $display("FAIL b2b_cycles[%0d] got %0d exp 0", i, cyc); end
            n_checks++; if (rd !== exp_data[i]) begin n_errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, rd, exp_data[i]); end
        end
        idle_cycle();
        n_checks++; if (num_dcache_access !== 16'd4) begin n_errors++; $display("FAIL b2b_access got %0d exp 4", num_dcache_access); end
        n_checks++; if (num_dcache_miss !== 16'd1) begin n_errors++; $display("FAIL b2b_miss got %0d exp 1", num_dcache_miss); end
        n_checks++; if (fill_cnt !== 1 || write_cnt !== 0) begin n_errors++; $display("FAIL b2b_traffic got fills %0d writes %0d exp 1 0", fill_cnt, write_cnt); end
    endtask

    task automatic test_write_hit();
        int cyc;
        logic [15:0] rd;
        do_access(1'b1, 16'h0012, 16'hBEEF, cyc, rd);
        n_checks++; if (cyc !== 3) begin n_errors++; $display("FAIL wh_cycles got %0d exp 3", cyc); end
        n_checks++; if (write_cnt !== 1) begin n_errors++; $display("FAIL wh_writes got %0d exp 1", write_cnt); end
        n_checks++; if (last_wr_addr !== 16'h0012) begin n_errors++; $display("FAIL wh_addr got %h exp 0012", last_wr_addr); end
        n_checks++; if (last_wr_data !== 16'hBEEF) begin n_errors++; $display("FAIL wh_data got %h exp BEEF", last_wr_data); end
        do_access(1'b0, 16'h0012, 16'h0, cyc, rd);
        idle_cycle();
        n_checks++; if (cyc !== 0) begin n_errors++; $display("FAIL wh_read_cycles got %0d exp 0", cyc); end
        n_checks++; if (rd !== 16'hBEEF) begin n_errors++; $display("FAIL wh_read_data got %h exp BEEF", rd); end
        n_checks++; if (num_dcache_miss !== 16'd1) begin n_errors++; $display("FAIL wh_miss got %0d exp 1", num_dcache_miss); end
        n_checks++; if (num_dcache_access !== 16'd6) begin n_errors++; $display("FAIL wh_access got %0d exp 6", num_dcache_access); end
    endtask

    task automatic test_write_miss();
        int cyc;
        logic [15:0] rd;
        do_access(1'b1, 16'h0040, 16'h00AA, cyc, rd);
        idle_cycle();
        n_checks++; if (cyc !== 3) begin n_errors++; $display("FAIL wm_cycles got %0d exp 3", cyc); end
        n_checks++; if (write_cnt !== 2) begin n_errors++; $display("FAIL wm_writes got %0d exp 2", write_cnt); end
        n_checks++; if (num_dcache_miss !== 16'd2) begin n_errors++; $display("FAIL wm_miss got %0d exp 2", num_dcache_miss); end
        n_checks++; if (fill_cnt !== 1) begin n_errors++; $display("FAIL wm_no_alloc got fills %0d exp 1", fill_cnt); end
        do_access(1'b0, 16'h0040, 16'h0, cyc, rd);
        idle_cycle();
        n_checks++; if (cyc !== 4) begin n_errors++; $display("FAIL wm_read_cycles got %0d exp 4", cyc); end
        n_checks++; if (rd !== 16'h00AA) begin n_errors++; $display("FAIL wm_read_data got %h exp 00AA", rd); end
        n_checks++; if (num_dcache_miss !== 16'd3) begin n_errors++; $display("FAIL wm_read_miss got %0d exp 3", num_dcache_miss); end
    endtask

    task automatic test_conflict();
        int cyc;
        logic [15:0] rd;
        logic [15:0] addrs [3];
        logic [15:0] exp_data [3];
        addrs[0] = 16'h0000; exp_data[0] = 16'hA500;
        addrs[1] = 16'h0010; exp_data[1] = 16'h1234;
        addrs[2] = 16'h0000; exp_data[2] = 16'hA500;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_access(1'b0, addrs[i], 16'h0, cyc, rd);
            n_checks++; if (cyc !== 4) begin n_errors++; $display("FAIL conf_cycles[%0d] got %0d exp 4", i, cyc); end
            n_checks++; if (rd !== exp_data[i]) begin n_errors++; $display("FAIL conf_rdata[%0d] got %h exp %h", i, rd, exp_data[i]); end
        end
        idle_cycle();
        n_checks++; if (num_dcache_miss !== 16'd3) begin n_errors++; $display("FAIL conf_miss got %0d exp 3", num_dcache_miss); end
        n_checks++; if (num_dcache_access !== 16'd3) begin n_errors++; $display("FAIL conf_access got %0d exp 3", num_dcache_access); end
    endtask

    task automatic test_reset_mid_fill();
        int cyc;
        logic [15:0] rd;
        resp_en = 1'b0;
        mem_readyM = 1'b0;
        mem_doneM = 1'b0;
        @(negedge clk);
        cpu_read = 1'b1;
        cpu_write = 1'b0;
        cpu_address = 16'h0020;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (mem_readM !== 1'b1) begin n_errors++; $display("FAIL rmf_readM got %b exp 1", mem_readM); end
        n_checks++; if (mem_address !== 16'h0020) begin n_errors++; $display("FAIL rmf_addr got %h exp 0020", mem_address); end
        @(negedge clk);
        reset = 1'b1;
        cpu_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (cpu_ready !== 1'b1) begin n_errors++; $display("FAIL rmf_ready got %b exp 1", cpu_ready); end
        n_checks++; if (mem_readM !== 1'b0) begin n_errors++; $display("FAIL rmf_readM_after got %b exp 0", mem_readM); end
        n_checks++; if (num_dcache_access !== 16'd0 || num_dcache_miss !== 16'd0) begin n_errors++; $display("FAIL rmf_counters got %0d %0d exp 0 0", num_dcache_access, num_dcache_miss); end
        // Stray fill response while IDLE
        @(negedge clk);
        mem_line = 64'hDEAD_DEAD_DEAD_DEAD;
        mem_readyM = 1'b1;
        @(negedge clk);
        mem_readyM = 1'b0;
        #1;
        n_checks++; if (cpu_ready !== 1'b1 || mem_readM !== 1'b0) begin n_errors++; $display("FAIL stray_state got ready %b readM %b exp 1 0", cpu_ready, mem_readM); end
        n_checks++; if (num_dcache_miss !== 16'd0) begin n_errors++; $display("FAIL stray_miss got %0d exp 0", num_dcache_miss); end
        resp_en = 1'b1;
        do_access(1'b0, 16'h0020, 16'h0, cyc, rd);
        idle_cycle();
        n_checks++; if (cyc !== 4) begin n_errors++; $display("FAIL rmf_reread_cycles got %0d exp 4", cyc); end
        n_checks++; if (rd !== 16'hA520) begin n_errors++; $display("FAIL rmf_reread_data got %h exp A520", rd); end
        n_checks++; if (num_dcache_miss !== 16'd1) begin n_errors++; $display("FAIL rmf_reread_miss got %0d exp 1", num_dcache_miss); end
        n_checks++; if (num_dcache_access !== 16'd1) begin n_errors++; $display("FAIL rmf_reread_access got %0d exp 1", num_dcache_access); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            model[i] = {8'hA5, 8'(i)};
        end
        model[16] = 16'h1234;
        test_reset();
        test_read_miss();
        test_back_to_back();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_reset_mid_fill();
        n_checks++; if (both_seen !== 1'b0) begin n_errors++; $display("FAIL rw_exclusive got %b exp 0", both_seen); end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
